uart_tx: RTL and testbench
==========================

// Module: uart_tx
//
// PURPOSE
//  8N1 UART transmitter: serialises bytes offered by the SOC onto the TXD pin.
//  Provides the transmit side of the SOC UART, whose RXD/TXD pins the core
//  currently leaves idle.
//  The core (or a later memory-mapped IO decoder) pushes bytes over a
//  valid/ready handshake. A one-byte holding register allows back-to-back
//  frames with no idle gap on the line.
//
// PARAMETERS
//  CLK_FREQ_HZ   12_000_000  system clock frequency in Hz
//  BAUD          115_200     line rate in bit/s
//  CLKS_PER_BIT  CLK_FREQ_HZ/BAUD (localparam, truncating divide; 104 at defaults)
//                Must be >= 2; otherwise elaboration fails with $error.
//
// PORTS
//  CLK       in   1  system clock; all logic on posedge
//  resetn    in   1  reset, synchronous, active-low
//  tx_data   in   8  byte to send; sampled only on a handshake edge
//  tx_valid  in   1  tx_data valid; hold it until the handshake completes
//  tx_ready  out  1  holding register empty; can accept a byte
//  tx_busy   out  1  frame in progress or byte pending
//  TXD       out  1  serial line, idle high, registered
//
// BEHAVIOUR
//  Reset (resetn=0 at posedge):
//    - TXD=1, tx_ready=1, tx_busy=0
//    - FSM goes to IDLE; holding register is emptied; baud counter is 0
//    - Reset mid-frame aborts the frame: TXD=1 after that edge, pending
//      byte discarded, no resume.
//  Handshake:
//    - A transfer occurs on a posedge where tx_valid && tx_ready.
//    - tx_ready is registered and equals !hold_full.
//  Load rule (accept edge; applies in IDLE, or on the last STOP cycle):
//    - If hold is empty and a transfer occurs: byte bypasses hold and goes
//      straight to the shifter. FSM enters START; TXD=0 after that same edge.
//    - Else if hold_full: shifter loads from hold, hold empties, and
//      tx_ready=1 after that edge.
//    - Otherwise, on the last STOP cycle: FSM enters IDLE, TXD=1.
//  Transfer while a frame is active (not a load point):
//    - Byte goes to hold; tx_ready=0 after that edge.
//    - While hold_full, tx_ready=0, so no further byte is accepted.
//  FSM and baud counter:
//    - baud_cnt counts 0..CLKS_PER_BIT-1 and clears on every bit boundary and
//      state entry. Width is $clog2(CLKS_PER_BIT).
//    - IDLE:  TXD=1.
//    - START: TXD=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
//    - DATA:  TXD=shift[0]. Each bit is held CLKS_PER_BIT cycles, LSB first.
//             Shift right and bit_idx++ (3 bits); after bit 7, go to STOP.
//    - STOP:  TXD=1 for CLKS_PER_BIT cycles; on its last cycle apply the
//             load rule.
//  Frame timing:
//    - One frame is exactly 10*CLKS_PER_BIT cycles.
//    - Consecutive frames abut exactly: the next start bit begins on the
//      cycle after the last stop cycle.
//  tx_busy:
//    - tx_busy = (state != IDLE) || hold_full.
//    - It drops on the edge that ends the last STOP cycle when no byte is
//      pending.
//  Input handling:
//    - tx_data changes outside a handshake edge are ignored.
//    - tx_valid deassertion before acceptance is legal and drops the offer.
//
// TESTING  (bench uses CLK_FREQ_HZ=16, BAUD=1 -> CLKS_PER_BIT=16, frame=160 clk)
//  1. Reset: resetn=0 for 5 clk with tx_valid=1, tx_data=8'hAA
//     -> TXD=1, tx_ready=1, tx_busy=0 throughout; no frame after release
//        until a new handshake occurs.
//  2. Single byte 8'h55, accepted at edge 0:
//     -> TXD=0 for clk 1-16.
//     -> Then 1,0,1,0,1,0,1,0 at 16 clk each.
//     -> Then 1 for 16 clk; tx_busy=0 after edge 160.
//  3. Back-to-back 8'hA5 then 8'h3C (second offered at edge 1):
//     -> Second byte is held; tx_ready=0 from edge 1 to edge 160.
//     -> Second start bit begins at clk 161, with no idle gap.
//  4. Third byte 8'h0F offered while hold is full, tx_valid held:
//     -> Not accepted until edge 160.
//     -> Then transmitted immediately after frame 2, bit-exact.
//  5. Transfer of 8'h81 presented on the final STOP cycle of a frame
//     -> Bypass load; start bit begins on the next cycle; tx_ready stays 1.
//  6. Reset at clk 50 of frame 8'hFF with 8'h12 held:
//     -> TXD=1, tx_ready=1, tx_busy=0 after the edge.
//     -> A subsequent 8'h00 sends a clean frame; 8'h12 is never sent.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter for the SOC TXD pin.
// Bytes arrive over a valid/ready handshake. A one-byte holding register lets
// the next frame start on the cycle right after the previous stop bit, so
// back-to-back bytes leave no idle gap on the line.
module uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD        = 115_200
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       TXD
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  // Guarded so an illegal rate still elaborates far enough to report the error.
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx: CLKS_PER_BIT = CLK_FREQ_HZ / BAUD must be >= 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] baud_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      hold_q;
  logic            hold_full_q;
  logic            txd_q;

  logic xfer;
  logic bit_end;
  logic load_pt;

  assign tx_ready = ~hold_full_q;
  assign tx_busy  = (state_q != StIdle) || hold_full_q;
  assign TXD      = txd_q;

  assign xfer    = tx_valid && tx_ready;
  assign bit_end = (baud_cnt_q == CntMax);
  // A new frame may only start from idle or exactly as the stop bit finishes.
  assign load_pt = (state_q == StIdle) || ((state_q == StStop) && bit_end);

  // Frame sequencer: at a load point pick the next byte, otherwise walk the bit cells.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q     <= StIdle;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
    end else if (load_pt) begin
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      if (xfer) begin
        // Nothing pending: the offered byte skips the holding register.
        shift_q <= tx_data;
        state_q <= StStart;
        txd_q   <= 1'b0;
      end else if (hold_full_q) begin
        shift_q     <= hold_q;
        hold_full_q <= 1'b0;
        state_q     <= StStart;
        txd_q       <= 1'b0;
      end else begin
        state_q <= StIdle;
        txd_q   <= 1'b1;
      end
    end else begin
      if (xfer) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end
      baud_cnt_q <= bit_end ? '0 : baud_cnt_q + 1'b1;
      case (state_q)
        StStart: begin
          if (bit_end) begin
            state_q <= StData;
            txd_q   <= shift_q[0];
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
              txd_q   <= 1'b1;
            end else begin
              // LSB first: expose the next bit while shifting it down.
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        default: begin
          // Stop bit mid-cell keeps the line high; idle is always a load point.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx at CLKS_PER_BIT=16 (160-clock frames).
// The reference model keeps a list of accepted bytes with their accept and
// frame-start edges and derives the line, tx_ready and tx_busy arithmetically.
module tb_uart_tx;

  localparam int unsigned CLK_FREQ_HZ = 16;
  localparam int unsigned BAUD        = 1;
  localparam int          CPB         = CLK_FREQ_HZ / BAUD;
  localparam int          FRAME       = 10 * CPB;

  logic       CLK      = 1'b0;
  logic       resetn   = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_busy;
  logic       TXD;

  int total = 0;
  int bad   = 0;

  uart_tx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD)
  ) dut (
    .CLK     (CLK),
    .resetn  (resetn),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_busy (tx_busy),
    .TXD     (TXD)
  );

  always #5 CLK = ~CLK;

  // Reference model: cyc is the index of the most recent posedge.
  int         cyc      = 0;
  int         last_end = 0;
  int         fr_acc[$];
  int         fr_start[$];
  logic [7:0] fr_byte[$];

  // Ready after edge t is low only while some byte waits for its frame to start.
  function automatic logic m_ready(int t);
    for (int i = 0; i < fr_acc.size(); i++)
      if (fr_acc[i] <= t && t < fr_start[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_busy(int t);
    for (int i = 0; i < fr_acc.size(); i++)
      if (fr_acc[i] <= t && t < fr_start[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  // Line level after edge t: start cell 0, data cells 1..8 LSB first, stop cell 9.
  function automatic logic m_txd(int t);
    int         slot;
    logic [7:0] b;
    for (int i = 0; i < fr_start.size(); i++) begin
      if (fr_start[i] <= t && t < fr_start[i] + FRAME) begin
        slot = (t - fr_start[i]) / CPB;
        b    = fr_byte[i];
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
      end
    end
    return 1'b1;
  endfunction

  // Model update: a byte starts at its accept edge or when the previous frame ends.
  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (!resetn) begin
      fr_acc.delete();
      fr_start.delete();
      fr_byte.delete();
      last_end = cyc;
    end else if (tx_valid && m_ready(cyc - 1)) begin
      fr_acc.push_back(cyc);
      fr_start.push_back((cyc > last_end) ? cyc : last_end);
      fr_byte.push_back(tx_data);
      last_end = fr_start[fr_start.size()-1] + FRAME;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (TXD !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got txd=%b ready=%b busy=%b want 1 1 0",
                 cyc, TXD, tx_ready, tx_busy);
      end
    end
    resetn   = 1'b1;
    tx_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      total++;
      if (TXD !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got txd=%b ready=%b busy=%b want 1 1 0",
                 cyc, TXD, tx_ready, tx_busy);
      end
    end
  endtask

  task automatic test_single();
    int         e0;
    logic [7:0] pat;
    logic       exp;
    pat      = 8'h55;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    tick();
    e0       = cyc;
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    for (int k = 0; k <= FRAME; k++) begin
      if (k < CPB) exp = 1'b0;
      else if (k < 9 * CPB) exp = pat[(k - CPB) / CPB];
      else exp = 1'b1;
      total++;
      if (TXD !== exp) begin
        bad++;
        $display("FAIL single_txd k=%0d got=%b want=%b", k, TXD, exp);
      end
      total++;
      if (tx_busy !== (k < FRAME)) begin
        bad++;
        $display("FAIL single_busy k=%0d got=%b want=%b", k, tx_busy, k < FRAME);
      end
      total++;
      if (tx_ready !== 1'b1) begin
        bad++;
        $display("FAIL single_ready k=%0d got=%b want=1", k, tx_ready);
      end
      if (k < FRAME) tick();
    end
    if (cyc != e0 + FRAME) $fatal(1, "bench sequencing error");
  endtask

  task automatic test_back_to_back();
    int   e0;
    int   acc3;
    logic rdy;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    e0      = cyc;
    tx_data = 8'h3C;
    tick();
    total++;
    if (tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_hold_ready got=%b want=0", tx_ready);
    end
    tx_data = 8'h0F;
    acc3    = -1;
    while (cyc < e0 + 3 * FRAME + 5) begin
      rdy = tx_ready;
      tick();
      if (tx_valid && rdy) begin
        acc3     = cyc;
        tx_valid = 1'b0;
        tx_data  = 8'h99;
      end
      total++;
      if (TXD !== m_txd(cyc)) begin
        bad++;
        $display("FAIL b2b_txd cyc=%0d got=%b want=%b", cyc, TXD, m_txd(cyc));
      end
      total++;
      if (tx_ready !== m_ready(cyc)) begin
        bad++;
        $display("FAIL b2b_ready cyc=%0d got=%b want=%b", cyc, tx_ready, m_ready(cyc));
      end
      total++;
      if (tx_busy !== m_busy(cyc)) begin
        bad++;
        $display("FAIL b2b_busy cyc=%0d got=%b want=%b", cyc, tx_busy, m_busy(cyc));
      end
      if (cyc == e0 + FRAME || cyc == e0 + 2 * FRAME) begin
        total++;
        if (TXD !== 1'b0) begin
          bad++;
          $display("FAIL b2b_next_start cyc=%0d got=%b want=0", cyc, TXD);
        end
      end
    end
    total++;
    if (acc3 < e0 + FRAME) begin
      bad++;
      $display("FAIL b2b_third_accept edge=%0d want>=%0d", acc3 - e0, FRAME);
    end
    total++;
    if (tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_final_busy got=%b want=0", tx_busy);
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_stop_edge();
    int e0;
    tx_data  = 8'($urandom);
    tx_valid = 1'b1;
    tick();
    e0       = cyc;
    tx_valid = 1'b0;
    while (cyc < e0 + FRAME - 1) begin
      tick();
      total++;
      if (TXD !== m_txd(cyc)) begin
        bad++;
        $display("FAIL stop_edge_txd cyc=%0d got=%b want=%b", cyc, TXD, m_txd(cyc));
      end
    end
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    total++;
    if (TXD !== 1'b0 || tx_ready !== 1'b1 || tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL stop_edge_bypass got txd=%b ready=%b busy=%b want 0 1 1",
               TXD, tx_ready, tx_busy);
    end
    while (cyc < e0 + 2 * FRAME) begin
      tick();
      total++;
      if (TXD !== m_txd(cyc) || tx_ready !== m_ready(cyc) || tx_busy !== m_busy(cyc)) begin
        bad++;
        $display("FAIL stop_edge_frame cyc=%0d got txd=%b ready=%b busy=%b want %b %b %b",
                 cyc, TXD, tx_ready, tx_busy, m_txd(cyc), m_ready(cyc), m_busy(cyc));
      end
    end
    total++;
    if (tx_busy !== 1'b0 || TXD !== 1'b1) begin
      bad++;
      $display("FAIL stop_edge_end got busy=%b txd=%b want 0 1", tx_busy, TXD);
    end
  endtask

  task automatic test_reset_mid();
    int   e0;
    int   e1;
    logic exp;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    e0      = cyc;
    tx_data = 8'h12;
    tick();
    tx_valid = 1'b0;
    total++;
    if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_held got ready=%b busy=%b want 0 1", tx_ready, tx_busy);
    end
    while (cyc < e0 + 49) tick();
    resetn = 1'b0;
    tick();
    total++;
    if (TXD !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_abort got txd=%b ready=%b busy=%b want 1 1 0",
               TXD, tx_ready, tx_busy);
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick();
    e1       = cyc;
    tx_valid = 1'b0;
    // Frame of 0x00: low through start and all data cells, then high forever.
    for (int k = 0; k < 2 * FRAME + 20; k++) begin
      exp = (k < 9 * CPB) ? 1'b0 : 1'b1;
      total++;
      if (TXD !== exp) begin
        bad++;
        $display("FAIL reset_mid_txd k=%0d got=%b want=%b", k, TXD, exp);
      end
      total++;
      if (tx_busy !== (k < FRAME)) begin
        bad++;
        $display("FAIL reset_mid_busy k=%0d got=%b want=%b", k, tx_busy, k < FRAME);
      end
      tick();
    end
    if (cyc <= e1) $fatal(1, "bench sequencing error");
  endtask

  task automatic test_random();
    int   gap;
    int   left;
    logic rdy;
    gap  = 3;
    left = 0;
    for (int c = 0; c < 2600; c++) begin
      rdy = tx_ready;
      tick();
      if (tx_valid) begin
        if (rdy) begin
          tx_valid = 1'b0;
          gap      = $urandom_range(1, 60);
        end else begin
          left--;
          if (left == 0) begin
            tx_valid = 1'b0;
            gap      = $urandom_range(1, 60);
          end
        end
      end else begin
        tx_data = 8'($urandom);
        gap--;
        if (gap <= 0 && c < 2100) begin
          tx_valid = 1'b1;
          left     = $urandom_range(1, 200);
        end
      end
      total++;
      if (TXD !== m_txd(cyc)) begin
        bad++;
        $display("FAIL rand_txd cyc=%0d got=%b want=%b", cyc, TXD, m_txd(cyc));
      end
      total++;
      if (tx_ready !== m_ready(cyc)) begin
        bad++;
        $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, tx_ready, m_ready(cyc));
      end
      total++;
      if (tx_busy !== m_busy(cyc)) begin
        bad++;
        $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc, tx_busy, m_busy(cyc));
      end
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stop_edge();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
